// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared LC-3b datapath types for the writeback path.
//   lc3b_word     : 16-bit datapath word
//   lc3b_reg      : 3-bit register index (R0..R7)
//   lc3b_wb_req   : one writeback request / output-stage entry
//   LC3B_NUM_REGS : number of architectural registers
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;

    localparam int LC3B_NUM_REGS = 8;

    typedef struct packed {
        logic     valid;
        lc3b_reg  dest;
        lc3b_word data;
    } lc3b_wb_req;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin priority picker.
//   req : request vector
//   ptr : index holding highest priority this cycle (must be < N)
//   en  : when low no grant is issued
//   gnt : one-hot grant (all zero when nothing wins)
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         gnt
);

    localparam int PW = $clog2(N);

    // pos carries one extra bit so ptr+i can exceed N before folding back.
    logic [PW:0] pos;
    logic        found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (PW+1)'(i);
            if (pos >= (PW+1)'(N))
                pos = pos - (PW+1)'(N);
            if (en && !found && req[pos[PW-1:0]]) begin
                gnt[pos[PW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter. NUM_REQ writeback sources compete
// round-robin for a single registered output stage that drives the
// register file write port.
//   clk, reset_n        : clock, async active-low reset
//   req_valid/dest/data : per-requester write requests
//   req_ready           : one-hot grant (transfer on valid & ready)
//   hold                : freezes the write port
//   load/dest/data_in   : register file write enable/address/data
//   pending             : per-register "accepted but not yet written"
//   wb_count            : saturating count of performed writes
module regfile_wb_arbiter
    import lc3b_types::*;
#(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  lc3b_reg  [NUM_REQ-1:0]    req_dest,
    input  lc3b_word [NUM_REQ-1:0]    req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      hold,
    output logic                      load,
    output lc3b_reg                   dest,
    output lc3b_word                  data_in,
    output logic [LC3B_NUM_REGS-1:0]  pending,
    output logic [CNT_W-1:0]          wb_count
);

    localparam int PW = $clog2(NUM_REQ);

    lc3b_wb_req                out_q;
    lc3b_wb_req                win;
    logic [PW-1:0]             rr_ptr;
    logic [PW-1:0]             win_idx;
    logic [PW-1:0]             ptr_next;
    logic [NUM_REQ-1:0]        gnt;
    logic [LC3B_NUM_REGS-1:0]  pending_next;
    logic                      accept_en;
    logic                      accept;
    logic                      drain;

    assign drain = out_q.valid & ~hold;

    // Accepting while draining keeps one write per cycle. Gating with
    // reset_n keeps grants off for the whole reset window.
    assign accept_en = reset_n & (~out_q.valid | ~hold);

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .en  (accept_en),
        .gnt (gnt)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

    always_comb begin
        win     = '0;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win.dest = req_dest[i];
                win.data = req_data[i];
                win_idx  = PW'(i);
            end
        end
        win.valid = accept;
    end

    assign ptr_next = (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + PW'(1);

    // Set beats clear: an accept to the register being drained this
    // cycle must leave its pending bit up.
    always_comb begin
        pending_next = pending;
        if (drain)
            pending_next[out_q.dest] = 1'b0;
        if (accept)
            pending_next[win.dest] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q    <= '0;
            rr_ptr   <= '0;
            pending  <= '0;
            wb_count <= '0;
        end else begin
            if (accept) begin
                out_q  <= win;
                rr_ptr <= ptr_next;
            end else if (drain) begin
                out_q.valid <= 1'b0;
            end
            pending <= pending_next;
            if (drain && (wb_count != '1))
                wb_count <= wb_count + CNT_W'(1);
        end
    end

    assign load    = drain;
    assign dest    = out_q.dest;
    assign data_in = out_q.data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    import lc3b_types::*;

    localparam int N = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req_valid;
    lc3b_reg  [N-1:0]  req_dest;
    lc3b_word [N-1:0]  req_data;
    logic [N-1:0]      req_ready;
    logic              hold;
    logic              load;
    lc3b_reg           dest;
    lc3b_word          data_in;
    logic [7:0]        pending;
    logic [15:0]       wb_count;

    regfile_wb_arbiter #(.NUM_REQ(N), .CNT_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_dest  (req_dest),
        .req_data  (req_data),
        .req_ready (req_ready),
        .hold      (hold),
        .load      (load),
        .dest      (dest),
        .data_in   (data_in),
        .pending   (pending),
        .wb_count  (wb_count)
    );

    always #5 clk = ~clk;

    // Reference model: queue of accepted-but-unwritten writes (the spec
    // allows at most one), round-robin pointer, saturating write count.
    typedef struct { logic [2:0] dest; logic [15:0] data; } wr_t;
    wr_t         exp_q[$];
    int          m_ptr  = 0;
    logic [15:0] m_cnt  = 16'd0;
    int          fired  = -1;
    int          n_chk  = 0;
    int          n_fail = 0;

    logic [7:0]   pexp;
    logic         exp_load;
    logic [N-1:0] exp_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the write port against the head of the queue.
    always @(negedge clk) begin
        if (reset_n) begin
            pexp = (exp_q.size() != 0) ? (8'd1 << exp_q[0].dest) : 8'd0;
            check("pending", {24'd0, pending}, {24'd0, pexp});
            check("wb_count", {16'd0, wb_count}, {16'd0, m_cnt});
            exp_load = (exp_q.size() != 0) && !hold;
            check("load", {31'd0, load}, {31'd0, exp_load});
            if (exp_load) begin
                check("dest", {29'd0, dest}, {29'd0, exp_q[0].dest});
                check("data_in", {16'd0, data_in}, {16'd0, exp_q[0].data});
                void'(exp_q.pop_front());
                if (m_cnt != 16'hFFFF) m_cnt++;
            end
        end
    end

    // Arbitration model: decides who should win this cycle and queues
    // the expected write.
    always @(negedge clk) begin
        #1;
        if (reset_n) begin
            exp_rdy = '0;
            fired   = -1;
            if (exp_q.size() == 0 || !hold) begin
                for (int i = 0; i < N; i++) begin
                    if (fired < 0 && req_valid[(m_ptr + i) % N])
                        fired = (m_ptr + i) % N;
                end
            end
            if (fired >= 0) begin
                exp_rdy[fired] = 1'b1;
                exp_q.push_back('{req_dest[fired], req_data[fired]});
                m_ptr = (fired + 1) % N;
            end
            check("req_ready", {29'd0, req_ready}, {29'd0, exp_rdy});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (fired >= 0) begin
            req_valid[fired] = 1'b0;
            fired = -1;
        end
    endtask

    task automatic post(input int i, input logic [2:0] d, input logic [15:0] v);
        req_valid[i] = 1'b1;
        req_dest[i]  = d;
        req_data[i]  = v;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic raise_all_random();
        for (int i = 0; i < N; i++)
            if (!req_valid[i]) post(i, 3'($urandom), 16'($urandom));
    endtask

    initial begin
        reset_n   = 1'b0;
        hold      = 1'b0;
        req_valid = '0;
        req_dest  = '0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pending", {24'd0, pending}, 32'd0);
        check("reset_load", {31'd0, load}, 32'd0);
        check("reset_count", {16'd0, wb_count}, 32'd0);
        reset_n = 1'b1;

        // single request
        post(0, 3'd3, 16'h1234);
        idle(4);

        // all requesters continuously valid
        for (int k = 0; k < 7; k++) begin
            raise_all_random();
            step();
        end
        idle(3);

        // hold with a write parked in the output stage
        post(0, 3'd5, 16'hBEEF);
        step();
        hold = 1'b1;
        post(1, 3'd1, 16'h1111);
        post(2, 3'd4, 16'h2222);
        idle(3);
        hold = 1'b0;
        idle(5);

        // same destination from two requesters at once
        post(0, 3'd2, 16'h0001);
        post(1, 3'd2, 16'h0002);
        idle(4);

        // randomized traffic with random hold
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    post(i, 3'($urandom), 16'($urandom));
            hold = ($urandom_range(0, 4) == 0);
            step();
        end
        hold = 1'b0;
        idle(6);

        // asynchronous reset while a write sits in the output stage
        post(0, 3'd6, 16'hCAFE);
        step();
        post(1, 3'd7, 16'h7777);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_load", {31'd0, load}, 32'd0);
        check("async_pending", {24'd0, pending}, 32'd0);
        check("async_count", {16'd0, wb_count}, 32'd0);
        check("async_ready", {29'd0, req_ready}, 32'd0);
        exp_q.delete();
        m_ptr = 0;
        m_cnt = 16'd0;
        fired = -1;
        @(negedge clk);
        #2;
        check("reset_ready", {29'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(4);

        // saturation: full-throughput writes past the counter limit
        for (int k = 0; k < 65540; k++) begin
            raise_all_random();
            step();
        end
        check("count_saturated", {16'd0, wb_count}, 32'h0000FFFF);
        idle(4);
        check("count_stays_saturated", {16'd0, wb_count}, 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
